float_multi_unit: RTL and testbench
===================================

Name:
float_multi_unit

Overview:
- Registered 16-bit dual-mode multiplier for the E203 accelerator datapath.
- mode=1: IEEE-754 binary16 (FP16) multiply.
- mode=0: signed 16-bit integer multiply with saturation.
- One result per cycle, fixed 1-cycle latency, no handshake; used as the scalar multiply element in the accelerator's compute array.

Parameters:
- None. Widths are fixed: 16-bit operands, FP16 format with 1 sign, 5 exponent (bias 15) and 10 fraction bits.

Ports:
- clk      input   1   rising-edge clock
- rst_n    input   1   asynchronous active-low reset
- mode     input   1   1 = FP16 multiply, 0 = signed INT16 multiply
- input1   input   16  operand A
- input2   input   16  operand B
- result   output  16  registered product

Behaviour:
Timing and reset:
- Fully pipelined, latency 1: mode/input1/input2 sampled on a clk rising edge; result holds the product from that edge onward.
- result changes only on clk rising edges or reset; no combinational path from inputs to result.
- rst_n low: result = 16'h0000 immediately (asynchronous), held while low. Operations in flight at reset are discarded.
- First valid result appears at the first rising edge after rst_n deasserts.

FP16 mode (mode=1):
- Sign = sA XOR sB, for every class including zero, inf and NaN-free results.
- Special cases, by priority:
  - Either operand NaN (exp=31, frac≠0) -> canonical qNaN 16'h7E00.
  - inf × zero -> 16'h7E00.
  - inf × finite nonzero -> signed inf (exp=31, frac=0).
  - Zero × finite -> signed zero.
- Subnormal inputs (exp=0, frac≠0): significand 0.frac, effective exponent -14; normalise internally before multiply.
- Core multiply:
  - 11×11-bit significand product (22 bits).
  - Exponent = eA + eB - 15, kept signed with ≥7 bits.
  - Normalise by leading-one position.
- Rounding: round-to-nearest-even using guard, round and sticky bits. A mantissa carry-out from rounding increments the exponent.
- Overflow: unbiased exponent after rounding > 15 -> signed inf (0x7C00/0xFC00).
- Underflow (gradual): biased exponent < 1 -> right-shift significand into subnormal range, ORing shifted-out bits into sticky, then round RNE.
  - Rounding up to 0x0400 yields the smallest normal.
  - Total loss yields signed zero.
- Accuracy: result bit-exact to IEEE RNE.

INT mode (mode=0):
- Operands are two's complement; full 32-bit signed product formed.
- Result saturates to [-32768, 32767]:
  - product > 32767 -> 16'h7FFF
  - product < -32768 -> 16'h8000
  - otherwise the low 16 bits.

Mode switching:
- mode may change every cycle.
- Each result reflects the mode sampled in the same edge as its operands.

Test Plan:
- FP normals: 0x3E00 (1.5) × 0x4000 (2.0) -> 0x4200 (3.0); 0xC100 (-2.5) × 0x4400 (4.0) -> 0xC900 (-10.0), result one cycle after sampling edge.
- FP rounding/overflow: 0x3C01 × 0x3C01 -> 0x3C02 (RNE); 0x7BFF × 0x4000 -> 0x7C00; 0xFBFF × 0x4000 -> 0xFC00.
- FP specials/subnormals:
  - 0x7C00 × 0x0000 -> 0x7E00; 0x7E00 × 0x3C00 -> 0x7E00.
  - 0x0400 × 0x3800 -> 0x0200; 0x0001 × 0x3800 -> 0x0000 (tie to even).
  - 0x8000 × 0x3C00 -> 0x8000.
- INT mode: 300 × 200 -> 0x7FFF; -7 × 6 -> 0xFFD6; -256 × 128 -> 0x8000; -300 × 200 -> 0x8000.
- Back-to-back alternation: FP 1.5×2.0, INT -7×6, FP 0xC100×0x4400 on consecutive edges -> 0x4200, 0xFFD6, 0xC900 on consecutive cycles.
- Reset: rst_n pulled low mid-cycle while result=0x4200 -> result 0x0000 without clock edge; after release, first edge with 0x3C00×0x3C00, mode=1 -> 0x3C00.

Source files
------------

// File: rtl/float_multi_unit.sv
// Registered dual-mode 16-bit multiplier: IEEE binary16 multiply (RNE) or
// saturating signed INT16 multiply, selected per cycle, one-cycle latency.
`timescale 1ns/1ps

module float_multi_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic [15:0] input1,
    input  logic [15:0] input2,
    output logic [15:0] result
);

    // ---------------- FP16 operand decode ----------------
    logic [4:0]  w_ea, w_eb;
    logic [9:0]  w_fa, w_fb;
    logic        w_sign;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [10:0] w_ma, w_mb;
    logic [4:0]  w_xa, w_xb;

    assign w_ea   = input1[14:10];
    assign w_eb   = input2[14:10];
    assign w_fa   = input1[9:0];
    assign w_fb   = input2[9:0];
    assign w_sign = input1[15] ^ input2[15];

    assign w_a_nan  = (w_ea == 5'h1F) && (w_fa != 10'd0);
    assign w_b_nan  = (w_eb == 5'h1F) && (w_fb != 10'd0);
    assign w_a_inf  = (w_ea == 5'h1F) && (w_fa == 10'd0);
    assign w_b_inf  = (w_eb == 5'h1F) && (w_fb == 10'd0);
    assign w_a_zero = (w_ea == 5'd0)  && (w_fa == 10'd0);
    assign w_b_zero = (w_eb == 5'd0)  && (w_fb == 10'd0);

    // Subnormals carry a zero hidden bit and the same effective exponent as exp=1
    assign w_ma = {(w_ea != 5'd0), w_fa};
    assign w_mb = {(w_eb != 5'd0), w_fb};
    assign w_xa = (w_ea == 5'd0) ? 5'd1 : w_ea;
    assign w_xb = (w_eb == 5'd0) ? 5'd1 : w_eb;

    // ---------------- significand product and normalisation ----------------
    logic [21:0] w_prod;
    logic [4:0]  w_lead;
    logic [21:0] w_norm;
    logic signed [7:0] w_exp;

    assign w_prod = w_ma * w_mb;

    always_comb begin
        w_lead = 5'd0;
        for (int i = 0; i < 22; i++) begin
            if (w_prod[i]) begin
                w_lead = 5'(i);
            end
        end
    end

    // Leading one moved to bit 21; biased exponent = lead + xa + xb - 35
    assign w_norm = w_prod << (5'd21 - w_lead);
    assign w_exp  = $signed({3'b000, w_lead} + {3'b000, w_xa} + {3'b000, w_xb} - 8'd35);

    // ---------------- gradual underflow shift and RNE rounding ----------------
    logic [4:0]  w_shamt;
    logic [47:0] w_wide;
    logic [10:0] w_sig;
    logic        w_guard, w_sticky, w_inc;
    logic [11:0] w_rnd;
    logic signed [7:0] w_exp_fin;
    logic [9:0]  w_mant;

    always_comb begin
        w_shamt = 5'd0;
        if (w_exp < -8'sd24) begin
            w_shamt = 5'd26;
        end else if (w_exp < 8'sd1) begin
            w_shamt = 5'(8'sd1 - w_exp);
        end
    end

    // 26 trailing zeros keep every shifted-out bit visible to the sticky OR
    assign w_wide   = {w_norm, 26'd0} >> w_shamt;
    assign w_sig    = w_wide[47:37];
    assign w_guard  = w_wide[36];
    assign w_sticky = |w_wide[35:0];
    assign w_inc    = w_guard & (w_sticky | w_sig[0]);
    assign w_rnd    = {1'b0, w_sig} + {11'd0, w_inc};

    assign w_exp_fin = w_exp + $signed({7'd0, w_rnd[11]});
    assign w_mant    = w_rnd[11] ? w_rnd[10:1] : w_rnd[9:0];

    logic [15:0] w_fp_result;

    always_comb begin
        w_fp_result = {w_sign, w_exp_fin[4:0], w_mant};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_fp_result = 16'h7E00;
        end else if (w_a_inf || w_b_inf) begin
            w_fp_result = {w_sign, 5'h1F, 10'd0};
        end else if (w_a_zero || w_b_zero) begin
            w_fp_result = {w_sign, 15'd0};
        end else if (w_exp < 8'sd1) begin
            // Hidden-bit position doubles as the exponent LSB: a round-up to
            // 0x400 lands exactly on the smallest normal.
            w_fp_result = {w_sign, 4'd0, w_rnd[10:0]};
        end else if (w_exp_fin > 8'sd30) begin
            w_fp_result = {w_sign, 5'h1F, 10'd0};
        end
    end

    // ---------------- saturating INT16 multiply ----------------
    logic signed [31:0] w_iprod;
    logic [15:0]        w_int_result;

    assign w_iprod = $signed(input1) * $signed(input2);

    always_comb begin
        w_int_result = w_iprod[15:0];
        if (w_iprod > 32'sd32767) begin
            w_int_result = 16'h7FFF;
        end else if (w_iprod < -32'sd32768) begin
            w_int_result = 16'h8000;
        end
    end

    // ---------------- output register ----------------
    logic [15:0] r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= 16'h0000;
        end else begin
            r_result <= mode ? w_fp_result : w_int_result;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_float_multi_unit.sv
// Self-checking bench for float_multi_unit: directed cases plus randomized
// FP16/INT16 traffic checked against a real-arithmetic reference model.
`timescale 1ns/1ps

module tb_float_multi_unit;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [15:0] input1;
    logic [15:0] input2;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    float_multi_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode   (mode),
        .input1 (input1),
        .input2 (input2),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real fp_mag(input logic [15:0] v);
        int e;
        int f;
        e = int'(v[14:10]);
        f = int'(v[9:0]);
        if (e == 0) return real'(f) * pow2(-24);
        return real'(1024 + f) * pow2(e - 25);
    endfunction

    // Round a positive exact magnitude to the nearest-even FP16 code (15 bits).
    function automatic logic [14:0] fp_encode(input real x);
        int  e;
        real pw;
        real q;
        real n;
        real fr;
        int  fl;
        if (x >= 65520.0) return 15'h7C00;
        e  = 15;
        pw = 32768.0;
        while (pw > x && e > -14) begin
            pw = pw / 2.0;
            e  = e - 1;
        end
        q  = pw / 1024.0;
        n  = x / q;
        fl = $rtoi(n);
        fr = n - real'(fl);
        if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl = fl + 1;
        if (x < pw) return 15'(fl);
        return 15'(((e + 15) * 1024) + fl - 1024);
    endfunction

    function automatic logic [15:0] fp_ref(input logic [15:0] a, input logic [15:0] b);
        logic s;
        logic an, bn, ai, bi, az, bz;
        s  = a[15] ^ b[15];
        an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        az = (a[14:0] == 0);
        bz = (b[14:0] == 0);
        if (an || bn) return 16'h7E00;
        if ((ai && bz) || (bi && az)) return 16'h7E00;
        if (ai || bi) return {s, 15'h7C00};
        if (az || bz) return {s, 15'h0000};
        return {s, fp_encode(fp_mag(a) * fp_mag(b))};
    endfunction

    function automatic logic [15:0] int_ref(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        if (p > 32767) return 16'h7FFF;
        if (p < -32768) return 16'h8000;
        return 16'(p);
    endfunction

    // Drive one operation mid-cycle, sample result 1ns after the capturing edge.
    task automatic apply(input logic m, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        mode   = m;
        input1 = a;
        input2 = b;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        mode   = 1'b1;
        input1 = 16'h3C00;
        input2 = 16'h3C00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state got %h exp 0000", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fp_directed();
        logic [15:0] vec [12][3];
        vec = '{
            '{16'h3E00, 16'h4000, 16'h4200},
            '{16'hC100, 16'h4400, 16'hC900},
            '{16'h3C01, 16'h3C01, 16'h3C02},
            '{16'h7BFF, 16'h4000, 16'h7C00},
            '{16'hFBFF, 16'h4000, 16'hFC00},
            '{16'h7C00, 16'h0000, 16'h7E00},
            '{16'h7E00, 16'h3C00, 16'h7E00},
            '{16'h0400, 16'h3800, 16'h0200},
            '{16'h0001, 16'h3800, 16'h0000},
            '{16'h8000, 16'h3C00, 16'h8000},
            '{16'h03FF, 16'h3C01, 16'h0400},
            '{16'hFC00, 16'h3C00, 16'hFC00}
        };
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, vec[i][0], vec[i][1]);
            checks++;
            if (result !== vec[i][2]) begin
                errors++;
                $display("FAIL fp_directed[%0d] %h*%h got %h exp %h", i, vec[i][0], vec[i][1], result, vec[i][2]);
            end else begin
                $display("fp_directed[%0d] %h*%h -> %h", i, vec[i][0], vec[i][1], result);
            end
        end
    endtask

    task automatic test_int_directed();
        logic [15:0] vec [6][3];
        vec = '{
            '{16'd300,   16'd200, 16'h7FFF},
            '{16'hFFF9,  16'd6,   16'hFFD6},
            '{16'hFF00,  16'd128, 16'h8000},
            '{16'hFED4,  16'd200, 16'h8000},
            '{16'h8000,  16'hFFFF, 16'h7FFF},
            '{16'h0100,  16'hFF80, 16'h8000}
        };
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, vec[i][0], vec[i][1]);
            checks++;
            if (result !== vec[i][2]) begin
                errors++;
                $display("FAIL int_directed[%0d] %h*%h got %h exp %h", i, vec[i][0], vec[i][1], result, vec[i][2]);
            end else begin
                $display("int_directed[%0d] %h*%h -> %h", i, vec[i][0], vec[i][1], result);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, exp_v;
        logic        m;
        for (int i = 0; i < 400; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            m = 1'($urandom);
            // Bias some operands toward tiny exponents to exercise underflow
            if ((i % 4) == 0) a[14:10] = 5'($urandom_range(0, 4));
            if ((i % 8) == 1) b[14:10] = 5'($urandom_range(0, 8));
            exp_v = m ? fp_ref(a, b) : int_ref(a, b);
            apply(m, a, b);
            checks++;
            if (result !== exp_v) begin
                errors++;
                $display("FAIL random[%0d] mode=%0d %h*%h got %h exp %h", i, m, a, b, result, exp_v);
            end else begin
                $display("random[%0d] mode=%0d %h*%h -> %h", i, m, a, b, result);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        m   [3];
        logic [15:0] a   [3];
        logic [15:0] b   [3];
        logic [15:0] exv [3];
        m   = '{1'b1, 1'b0, 1'b1};
        a   = '{16'h3E00, 16'hFFF9, 16'hC100};
        b   = '{16'h4000, 16'h0006, 16'h4400};
        exv = '{16'h4200, 16'hFFD6, 16'hC900};
        for (int i = 0; i < 3; i++) begin
            apply(m[i], a[i], b[i]);
            checks++;
            if (result !== exv[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d] got %h exp %h", i, result, exv[i]);
            end else begin
                $display("back_to_back[%0d] -> %h", i, result);
            end
        end
    endtask

    task automatic test_reset_midcycle();
        apply(1'b1, 16'h3E00, 16'h4000);
        checks++;
        if (result !== 16'h4200) begin
            errors++;
            $display("FAIL pre_reset got %h exp 4200", result);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset got %h exp 0000", result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold got %h exp 0000", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 16'h3C00, 16'h3C00);
        checks++;
        if (result !== 16'h3C00) begin
            errors++;
            $display("FAIL post_reset got %h exp 3C00", result);
        end else begin
            $display("post_reset 3c00*3c00 -> %h", result);
        end
    endtask

    initial begin
        test_reset();
        test_fp_directed();
        test_int_directed();
        test_random();
        test_back_to_back();
        test_reset_midcycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
